// File: rtl/estacionamento_pkg.sv
// estacionamento_pkg: shared constants, width helper and zone event codes for the occupancy tracker.
package estacionamento_pkg;
    localparam int DEF_ZONES = 4;
    localparam int DEF_CAPACITY = 40;
    localparam int DEF_MARGIN = 2;

    localparam logic [1:0] EV_HOLD = 2'd0;
    localparam logic [1:0] EV_INC  = 2'd1;
    localparam logic [1:0] EV_DEC  = 2'd2;
    localparam logic [1:0] EV_ERR  = 2'd3;

    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/zone_counter.sv
// zone_counter: saturating per-zone vehicle counter with registered flags and error strobes.
module zone_counter
    import estacionamento_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int ALMOST_FULL_MARGIN = DEF_MARGIN,
    parameter int CNT_W = clog2w(DEF_CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             entry,
    input  logic             exit,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] nxt_count,
    output logic             vazio,
    output logic             cheio,
    output logic             quase_cheio,
    output logic             ovf,
    output logic             udf
);
    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] TH_V  = CNT_W'(CAPACITY - ALMOST_FULL_MARGIN);

    logic [1:0] ev;

    // saturation is decided on the current count before any add/sub
    always_comb begin
        ev = clear ? EV_HOLD :
             (entry && exit) ? EV_HOLD :
             entry ? ((count == CAP_V) ? EV_ERR : EV_INC) :
             exit ? ((count == '0) ? EV_ERR : EV_DEC) : EV_HOLD;
        nxt_count = clear ? '0 :
                    (ev == EV_INC) ? count + CNT_W'(1) :
                    (ev == EV_DEC) ? count - CNT_W'(1) : count;
        ovf = (ev == EV_ERR) && entry;
        udf = (ev == EV_ERR) && exit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            vazio       <= 1'b1;
            cheio       <= 1'b0;
            quase_cheio <= 1'b0;
        end else begin
            count       <= nxt_count;
            vazio       <= nxt_count == '0;
            cheio       <= nxt_count == CAP_V;
            quase_cheio <= nxt_count >= TH_V;
        end
    end
endmodule

// File: rtl/occupancy_tracker.sv
// occupancy_tracker: multi-zone parking occupancy with lot totals and sticky error flags.
module occupancy_tracker
    import estacionamento_pkg::*;
#(
    parameter int NUM_ZONES = DEF_ZONES,
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int ALMOST_FULL_MARGIN = DEF_MARGIN,
    localparam int CNT_W = clog2w(CAPACITY + 1),
    localparam int TOT_W = clog2w(NUM_ZONES * CAPACITY + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       err_clear,
    input  logic [NUM_ZONES-1:0]       entry,
    input  logic [NUM_ZONES-1:0]       exit,
    output logic [NUM_ZONES*CNT_W-1:0] occupancy,
    output logic [TOT_W-1:0]           total,
    output logic [NUM_ZONES-1:0]       vazio,
    output logic [NUM_ZONES-1:0]       cheio,
    output logic [NUM_ZONES-1:0]       quase_cheio,
    output logic                       lot_full,
    output logic                       lot_empty,
    output logic                       err_overflow,
    output logic                       err_underflow
);
    localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(NUM_ZONES * CAPACITY);

    logic [NUM_ZONES*CNT_W-1:0] nxt;
    logic [NUM_ZONES-1:0]       ovf;
    logic [NUM_ZONES-1:0]       udf;
    logic [TOT_W-1:0]           total_nxt;

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        zone_counter #(
            .CAPACITY(CAPACITY),
            .ALMOST_FULL_MARGIN(ALMOST_FULL_MARGIN),
            .CNT_W(CNT_W)
        ) u_zone (
            .clk(clk),
            .reset_n(reset_n),
            .clear(clear),
            .entry(entry[z]),
            .exit(exit[z]),
            .count(occupancy[z*CNT_W +: CNT_W]),
            .nxt_count(nxt[z*CNT_W +: CNT_W]),
            .vazio(vazio[z]),
            .cheio(cheio[z]),
            .quase_cheio(quase_cheio[z]),
            .ovf(ovf[z]),
            .udf(udf[z])
        );
    end

    always_comb begin
        total_nxt = '0;
        for (int i = 0; i < NUM_ZONES; i++)
            total_nxt = total_nxt + TOT_W'(nxt[i*CNT_W +: CNT_W]);
    end

    // every zone is capped at CAPACITY, so the sum hits its maximum only when all are full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total         <= '0;
            lot_full      <= 1'b0;
            lot_empty     <= 1'b1;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            total         <= total_nxt;
            lot_full      <= total_nxt == TOT_MAX;
            lot_empty     <= total_nxt == '0;
            err_overflow  <= (err_overflow & ~err_clear) | (|ovf);
            err_underflow <= (err_underflow & ~err_clear) | (|udf);
        end
    end
endmodule

// File: tb/tb_occupancy_tracker.sv
// tb_occupancy_tracker: vector table, corner sequences and random traffic against a counting model.
module tb_occupancy_tracker;
    localparam int NZ = 2;
    localparam int CAP = 4;
    localparam int MRG = 1;
    localparam int CW = 3;
    localparam int TW = 4;

    logic clk = 0;
    logic reset_n = 0;
    logic clear = 0;
    logic err_clear = 0;
    logic [NZ-1:0] entry = 0;
    logic [NZ-1:0] exit = 0;
    logic [NZ*CW-1:0] occupancy;
    logic [TW-1:0] total;
    logic [NZ-1:0] vazio, cheio, quase_cheio;
    logic lot_full, lot_empty, err_overflow, err_underflow;

    occupancy_tracker #(.NUM_ZONES(NZ), .CAPACITY(CAP), .ALMOST_FULL_MARGIN(MRG)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .err_clear(err_clear),
        .entry(entry), .exit(exit), .occupancy(occupancy), .total(total),
        .vazio(vazio), .cheio(cheio), .quase_cheio(quase_cheio),
        .lot_full(lot_full), .lot_empty(lot_empty),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cnt [NZ];
    bit eo, eu;

    typedef struct {
        bit       clr;
        bit       ec;
        bit [1:0] en;
        bit [1:0] ex;
        int       o0;
        int       o1;
        bit       xo;
        bit       xu;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int z = 0; z < NZ; z++) cnt[z] = 0;
        eo = 0;
        eu = 0;
    endfunction

    function automatic void model_apply(input bit clr, input bit ec, input bit [1:0] en, input bit [1:0] ex);
        bit no = 0, nu = 0;
        for (int z = 0; z < NZ; z++) begin
            if (clr) cnt[z] = 0;
            else if (en[z] && ex[z]) cnt[z] = cnt[z];
            else if (en[z]) begin
                if (cnt[z] == CAP) no = 1; else cnt[z]++;
            end else if (ex[z]) begin
                if (cnt[z] == 0) nu = 1; else cnt[z]--;
            end
        end
        eo = (eo && !ec) || no;
        eu = (eu && !ec) || nu;
    endfunction

    task automatic check_all(input string tag);
        int sum = 0;
        bit all_full = 1;
        for (int z = 0; z < NZ; z++) begin
            check({tag, " occ"}, int'(occupancy[z*CW +: CW]), cnt[z]);
            check({tag, " vazio"}, int'(vazio[z]), int'(cnt[z] == 0));
            check({tag, " cheio"}, int'(cheio[z]), int'(cnt[z] == CAP));
            check({tag, " quase"}, int'(quase_cheio[z]), int'(cnt[z] >= CAP - MRG));
            sum += cnt[z];
            if (cnt[z] != CAP) all_full = 0;
        end
        check({tag, " total"}, int'(total), sum);
        check({tag, " lot_full"}, int'(lot_full), int'(all_full));
        check({tag, " lot_empty"}, int'(lot_empty), int'(sum == 0));
        check({tag, " err_ovf"}, int'(err_overflow), int'(eo));
        check({tag, " err_udf"}, int'(err_underflow), int'(eu));
    endtask

    task automatic step(input bit clr, input bit ec, input bit [1:0] en, input bit [1:0] ex);
        clear = clr;
        err_clear = ec;
        entry = en;
        exit = ex;
        @(posedge clk);
        #1;
        model_apply(clr, ec, en, ex);
        clear = 0;
        err_clear = 0;
        entry = 0;
        exit = 0;
    endtask

    initial begin
        vecs[0]  = '{0, 0, 2'b01, 2'b00, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 2'b01, 2'b00, 2, 0, 0, 0};
        vecs[2]  = '{0, 0, 2'b01, 2'b00, 3, 0, 0, 0};
        vecs[3]  = '{0, 0, 2'b01, 2'b00, 4, 0, 0, 0};
        vecs[4]  = '{0, 0, 2'b01, 2'b00, 4, 0, 1, 0};
        vecs[5]  = '{0, 0, 2'b00, 2'b10, 4, 0, 1, 1};
        vecs[6]  = '{0, 1, 2'b00, 2'b00, 4, 0, 0, 0};
        vecs[7]  = '{0, 1, 2'b00, 2'b10, 4, 0, 0, 1};
        vecs[8]  = '{0, 0, 2'b01, 2'b01, 4, 0, 0, 1};
        vecs[9]  = '{0, 0, 2'b00, 2'b01, 3, 0, 0, 1};
        vecs[10] = '{0, 0, 2'b00, 2'b01, 2, 0, 0, 1};
        vecs[11] = '{0, 0, 2'b01, 2'b01, 2, 0, 0, 1};
        vecs[12] = '{0, 0, 2'b10, 2'b00, 2, 1, 0, 1};
        vecs[13] = '{0, 0, 2'b10, 2'b00, 2, 2, 0, 1};
        vecs[14] = '{0, 0, 2'b10, 2'b00, 2, 3, 0, 1};
        vecs[15] = '{0, 0, 2'b10, 2'b00, 2, 4, 0, 1};
        vecs[16] = '{0, 0, 2'b01, 2'b00, 3, 4, 0, 1};
        vecs[17] = '{0, 0, 2'b01, 2'b00, 4, 4, 0, 1};
        vecs[18] = '{0, 0, 2'b00, 2'b10, 4, 3, 0, 1};
        vecs[19] = '{1, 0, 2'b11, 2'b00, 0, 0, 0, 1};

        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a cycle with zone0 at 3
        for (int i = 0; i < 3; i++) step(0, 0, 2'b01, 2'b00);
        check("pre_reset occ0", int'(occupancy[CW-1:0]), 3);
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check("async occ", int'(occupancy), 0);
        check("async vazio", int'(vazio), 3);
        check("async lot_empty", int'(lot_empty), 1);
        check_all("async");
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].ec, vecs[i].en, vecs[i].ex);
            check($sformatf("vec%0d occ0", i), int'(occupancy[0 +: CW]), vecs[i].o0);
            check($sformatf("vec%0d occ1", i), int'(occupancy[CW +: CW]), vecs[i].o1);
            check($sformatf("vec%0d ovf", i), int'(err_overflow), int'(vecs[i].xo));
            check($sformatf("vec%0d udf", i), int'(err_underflow), int'(vecs[i].xu));
            check_all($sformatf("vec%0d", i));
        end

        // lot full and the exit that breaks it, seen in the same cycle as occupancy
        step(0, 0, 2'b11, 2'b00);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 2'b00);
        check("seq lot_full", int'(lot_full), 1);
        check("seq total8", int'(total), 8);
        step(0, 0, 2'b00, 2'b10);
        check("seq total7", int'(total), 7);
        check("seq lot_full_drop", int'(lot_full), 0);
        check("seq occ1", int'(occupancy[CW +: CW]), 3);
        check_all("seq");

        for (int n = 0; n < 400; n++) begin
            bit clr = ($urandom_range(0, 19) == 0);
            bit ec = ($urandom_range(0, 9) == 0);
            bit [1:0] en = 2'($urandom);
            bit [1:0] ex = 2'($urandom);
            step(clr, ec, en, ex);
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
